// File: rtl/cle_label_reader_if.sv
// Label-map reader bus: SRAM read port, bitmap byte write port and the
// per-label report stream, grouped so the reader and its peers share one bundle.
interface cle_label_reader_if;
  logic [9:0]  sram_a;
  logic [7:0]  sram_q;
  logic [6:0]  bm_a;
  logic [7:0]  bm_d;
  logic        bm_wr;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [7:0]  rpt_label;
  logic [10:0] rpt_count;

  modport master (
    output sram_a, bm_a, bm_d, bm_wr, rpt_valid, rpt_label, rpt_count,
    input  sram_q, rpt_ready
  );

  modport slave (
    input  sram_a, bm_a, bm_d, bm_wr, rpt_valid, rpt_label, rpt_count,
    output sram_q, rpt_ready
  );
endinterface

// File: rtl/cle_label_reader.sv
// Scans the 32x32 label map out of SRAM, repacks it as a 1-bit/pixel bitmap
// and streams a per-label pixel-count report over valid/ready.
module cle_label_reader #(
  parameter int MAX_LABELS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cle_label_reader_if.master   bus,
  output logic [7:0]           label_max,
  output logic                 overflow,
  output logic                 done
);

  localparam logic [7:0]  MAXL      = 8'(MAX_LABELS);
  localparam logic [10:0] SCAN_LAST = 11'd1025;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_REPORT, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [10:0]                  scan_cnt_q, scan_cnt_d;
  logic [9:0]                   sram_a_q, sram_a_d;
  logic [6:0]                   bm_a_q, bm_a_d;
  logic [7:0]                   bm_d_q, bm_d_d;
  logic [7:0]                   sh_q, sh_d;
  logic                         bm_wr_q, bm_wr_d;
  logic                         rpt_valid_q, rpt_valid_d;
  logic [7:0]                   rpt_label_q, rpt_label_d;
  logic [10:0]                  rpt_count_q, rpt_count_d;
  logic [7:0]                   label_max_q, label_max_d;
  logic                         overflow_q, overflow_d;
  logic                         done_q, done_d;
  logic [MAX_LABELS-1:0][10:0]  cnt_q, cnt_d;

  logic [7:0] pix_l, top, byte_now;
  logic [9:0] pix;
  logic       pix_vld;

  // Scan cycle c presents address c; its data is consumed in cycle c+1.
  always_comb begin
    top      = (label_max_q > MAXL) ? MAXL : label_max_q;
    pix_l    = bus.sram_q;
    pix      = 10'(scan_cnt_q - 11'd1);
    pix_vld  = (state_q == S_SCAN) && (scan_cnt_q != 11'd0) && (scan_cnt_q <= 11'd1024);
    byte_now = sh_q;
    byte_now[pix[2:0]] = (pix_l != 8'd0);
  end

  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    sram_a_d    = sram_a_q;
    bm_a_d      = bm_a_q;
    bm_d_d      = bm_d_q;
    sh_d        = sh_q;
    bm_wr_d     = 1'b0;
    rpt_valid_d = rpt_valid_q;
    rpt_label_d = rpt_label_q;
    rpt_count_d = rpt_count_q;
    label_max_d = label_max_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_CLEAR;
          sram_a_d = '0;
          done_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        cnt_d       = '0;
        label_max_d = '0;
        overflow_d  = 1'b0;
        done_d      = 1'b0;
        sram_a_d    = '0;
        scan_cnt_d  = '0;
        state_d     = S_SCAN;
      end
      S_SCAN: begin
        scan_cnt_d = scan_cnt_q + 11'd1;
        if (scan_cnt_q < 11'd1023) sram_a_d = sram_a_q + 10'd1;
        if (pix_vld) begin
          sh_d = byte_now;
          for (int i = 0; i < MAX_LABELS; i++)
            if (pix_l == 8'(i + 1)) cnt_d[i] = cnt_q[i] + 11'd1;
          if (pix_l > MAXL)        overflow_d  = 1'b1;
          if (pix_l > label_max_q) label_max_d = pix_l;
          if (pix[2:0] == 3'd7) begin
            bm_wr_d = 1'b1;
            bm_a_d  = pix[9:3];
            bm_d_d  = byte_now;
          end
        end
        // Counters and label_max are final here: the last pixel landed last cycle.
        if (scan_cnt_q == SCAN_LAST) begin
          state_d = S_REPORT;
          if (top != 8'd0) begin
            rpt_valid_d = 1'b1;
            rpt_label_d = 8'd1;
            rpt_count_d = cnt_q[0];
          end
        end
      end
      S_REPORT: begin
        if (!rpt_valid_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (bus.rpt_ready) begin
          if (rpt_label_q == top) begin
            rpt_valid_d = 1'b0;
            state_d     = S_DONE;
            done_d      = 1'b1;
          end else begin
            rpt_label_d = rpt_label_q + 8'd1;
            for (int i = 0; i < MAX_LABELS; i++)
              if (rpt_label_q == 8'(i)) rpt_count_d = cnt_q[i];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      scan_cnt_q  <= '0;
      sram_a_q    <= '0;
      bm_a_q      <= '0;
      bm_d_q      <= '0;
      sh_q        <= '0;
      bm_wr_q     <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_label_q <= '0;
      rpt_count_q <= '0;
      label_max_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      sram_a_q    <= sram_a_d;
      bm_a_q      <= bm_a_d;
      bm_d_q      <= bm_d_d;
      sh_q        <= sh_d;
      bm_wr_q     <= bm_wr_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_label_q <= rpt_label_d;
      rpt_count_q <= rpt_count_d;
      label_max_q <= label_max_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.sram_a    = sram_a_q;
  assign bus.bm_a      = bm_a_q;
  assign bus.bm_d      = bm_d_q;
  assign bus.bm_wr     = bm_wr_q;
  assign bus.rpt_valid = rpt_valid_q;
  assign bus.rpt_label = rpt_label_q;
  assign bus.rpt_count = rpt_count_q;
  assign label_max     = label_max_q;
  assign overflow      = overflow_q;
  assign done          = done_q;

endmodule

// File: tb/tb_cle_label_reader.sv
// Randomized bench for cle_label_reader: an SRAM model feeds label maps and a
// map-level reference computes the expected bitmap bytes and report words.
module tb_cle_label_reader;
  localparam int MAXL = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] label_max;
  logic       overflow;
  logic       done;

  cle_label_reader_if bus ();

  cle_label_reader #(.MAX_LABELS(MAXL)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .label_max(label_max), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) bus.sram_q <= mem[bus.sram_a];

  int n_checks = 0;
  int n_fail   = 0;

  // 0: always ready, 1: ready one cycle in three, 2: random
  int ready_mode = 0;
  int ready_cyc  = 0;
  always @(posedge clk) begin
    #2;
    ready_cyc++;
    case (ready_mode)
      0:       bus.rpt_ready = 1'b1;
      1:       bus.rpt_ready = (ready_cyc % 3 == 0);
      default: bus.rpt_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [6:0]  bm_a_log [$];
  logic [7:0]  bm_d_log [$];
  logic [7:0]  w_lbl [$];
  logic [10:0] w_cnt [$];
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_lbl;
  logic [10:0] prev_cnt;

  always @(negedge clk) begin
    if (!reset) prev_stall = 1'b0;
    else begin
      if (bus.bm_wr) begin
        bm_a_log.push_back(bus.bm_a);
        bm_d_log.push_back(bus.bm_d);
      end
      if (prev_stall && (!bus.rpt_valid || bus.rpt_label !== prev_lbl || bus.rpt_count !== prev_cnt))
        stall_err++;
      if (bus.rpt_valid && bus.rpt_ready) begin
        w_lbl.push_back(bus.rpt_label);
        w_cnt.push_back(bus.rpt_count);
      end
      prev_stall = bus.rpt_valid && !bus.rpt_ready;
      prev_lbl   = bus.rpt_label;
      prev_cnt   = bus.rpt_count;
    end
  end

  // Reference: expected results straight from the map contents.
  logic [7:0] exp_bm [128];
  int         exp_lbl [$];
  int         exp_cnt [$];
  int         exp_max;
  bit         exp_ovf;

  task automatic build_model();
    int cnt [256];
    int top;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (exp_bm[k]) exp_bm[k] = 8'h00;
    exp_max = 0;
    exp_ovf = 0;
    for (int p = 0; p < 1024; p++) begin
      int l = int'(mem[p]);
      if (l != 0) exp_bm[p / 8] = exp_bm[p / 8] | 8'(1 << (p % 8));
      cnt[l]++;
      if (l > MAXL) exp_ovf = 1;
      if (l > exp_max) exp_max = l;
    end
    exp_lbl.delete();
    exp_cnt.delete();
    top = (exp_max < MAXL) ? exp_max : MAXL;
    for (int l = 1; l <= top; l++) begin
      exp_lbl.push_back(l);
      exp_cnt.push_back(cnt[l]);
    end
  endtask

  task automatic fill_rand(input int max_lab, input int pct);
    for (int p = 0; p < 1024; p++)
      mem[p] = ($urandom_range(0, 99) < pct) ? 8'($urandom_range(1, max_lab)) : 8'h00;
  endtask

  task automatic run_scan(output int cycles);
    bm_a_log.delete(); bm_d_log.delete();
    w_lbl.delete(); w_cnt.delete();
    stall_err = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cycles = 0;
    while (!done && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
    end
    @(negedge clk);
  endtask

  task automatic check_scan(input string tag);
    n_checks++;
    if (bm_a_log.size() != 128)
      begin n_fail++; $display("FAIL %s strobes: got %0d want 128", tag, bm_a_log.size()); end
    for (int k = 0; k < 128 && k < bm_a_log.size(); k++) begin
      n_checks++;
      if (bm_a_log[k] !== 7'(k) || bm_d_log[k] !== exp_bm[k]) begin
        n_fail++;
        $display("FAIL %s bm[%0d]: got a=%0d d=%h want a=%0d d=%h", tag, k, bm_a_log[k], bm_d_log[k], k, exp_bm[k]);
      end
    end
    n_checks++;
    if (w_lbl.size() != exp_lbl.size())
      begin n_fail++; $display("FAIL %s words: got %0d want %0d", tag, w_lbl.size(), exp_lbl.size()); end
    for (int i = 0; i < w_lbl.size() && i < exp_lbl.size(); i++) begin
      n_checks++;
      if (int'(w_lbl[i]) != exp_lbl[i] || int'(w_cnt[i]) != exp_cnt[i]) begin
        n_fail++;
        $display("FAIL %s word%0d: got (%0d,%0d) want (%0d,%0d)", tag, i, w_lbl[i], w_cnt[i], exp_lbl[i], exp_cnt[i]);
      end
    end
    n_checks++;
    if (int'(label_max) != exp_max || overflow !== exp_ovf)
      begin n_fail++; $display("FAIL %s max/ovf: got %0d/%b want %0d/%b", tag, label_max, overflow, exp_max, exp_ovf); end
    n_checks++;
    if (done !== 1'b1 || bus.sram_a !== 10'd1023 || bus.bm_wr !== 1'b0)
      begin n_fail++; $display("FAIL %s done_state: got done=%b a=%0d wr=%b want 1/1023/0", tag, done, bus.sram_a, bus.bm_wr); end
    n_checks++;
    if (stall_err != 0)
      begin n_fail++; $display("FAIL %s stall_hold: got %0d changes want 0", tag, stall_err); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.sram_a !== 10'd0 || bus.bm_a !== 7'd0 || bus.bm_d !== 8'd0 || bus.bm_wr !== 1'b0)
      begin n_fail++; $display("FAIL reset_bm: got a=%0d bma=%0d bmd=%h wr=%b want 0", bus.sram_a, bus.bm_a, bus.bm_d, bus.bm_wr); end
    n_checks++;
    if (bus.rpt_valid !== 1'b0 || bus.rpt_label !== 8'd0 || bus.rpt_count !== 11'd0)
      begin n_fail++; $display("FAIL reset_rpt: got v=%b l=%0d c=%0d want 0", bus.rpt_valid, bus.rpt_label, bus.rpt_count); end
    n_checks++;
    if (label_max !== 8'd0 || overflow !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL reset_status: got max=%0d ovf=%b done=%b want 0", label_max, overflow, done); end
    reset = 1'b1;
  endtask

  task automatic test_all_zero();
    int cyc;
    foreach (mem[p]) mem[p] = 8'h00;
    build_model();
    ready_mode = 0;
    run_scan(cyc);
    check_scan("all_zero");
    n_checks++;
    if (cyc != 1028) begin n_fail++; $display("FAIL all_zero latency: got %0d want 1028", cyc); end
  endtask

  task automatic test_all_one();
    int cyc;
    foreach (mem[p]) mem[p] = 8'h01;
    build_model();
    run_scan(cyc);
    check_scan("all_one");
    n_checks++;
    if (w_cnt.size() != 1 || w_cnt[0] !== 11'd1024 || bm_d_log.size() == 0 || bm_d_log[0] !== 8'hFF)
      begin n_fail++; $display("FAIL all_one word: got n=%0d cnt=%0d want 1 word count 1024 byte FF", w_cnt.size(), (w_cnt.size() > 0) ? w_cnt[0] : 0); end
  endtask

  task automatic test_corners();
    int cyc;
    foreach (mem[p]) mem[p] = 8'h00;
    mem[0] = 8'd3; mem[1023] = 8'd1;
    build_model();
    ready_mode = 0;
    run_scan(cyc);
    check_scan("corners");
    n_checks++;
    if (bm_d_log.size() != 128 || bm_d_log[0] !== 8'h01 || bm_d_log[127] !== 8'h80)
      begin n_fail++; $display("FAIL corners bytes: got n=%0d want byte0=01 byte127=80", bm_d_log.size()); end
    n_checks++;
    if (cyc != 1030) begin n_fail++; $display("FAIL corners throughput: got %0d cycles want 1030", cyc); end
  endtask

  task automatic test_stall();
    int cyc;
    ready_mode = 1;
    build_model();
    run_scan(cyc);
    check_scan("stall");
    n_checks++;
    if (w_lbl.size() != 3) begin n_fail++; $display("FAIL stall words: got %0d want 3", w_lbl.size()); end
  endtask

  task automatic test_overflow();
    int cyc;
    fill_rand(10, 40);
    mem[5] = 8'd200;
    build_model();
    ready_mode = 2;
    run_scan(cyc);
    check_scan("overflow");
    n_checks++;
    if (overflow !== 1'b1 || label_max !== 8'd200 || w_lbl.size() != 64)
      begin n_fail++; $display("FAIL overflow flags: got ovf=%b max=%0d n=%0d want 1/200/64", overflow, label_max, w_lbl.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int it = 0; it < 3; it++) begin
      fill_rand((it == 0) ? 80 : 30, 25 + 20 * it);
      build_model();
      ready_mode = it % 3;
      run_scan(cyc);
      check_scan($sformatf("rand%0d", it));
    end
  endtask

  task automatic test_reset_mid_scan();
    int n = 0;
    int cyc;
    fill_rand(50, 50);
    build_model();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (bus.sram_a != 10'd500 && n < 2000) begin @(negedge clk); n++; end
    n_checks++;
    if (bus.sram_a !== 10'd500) begin n_fail++; $display("FAIL midscan reach: got a=%0d want 500", bus.sram_a); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.sram_a !== 10'd0 || bus.bm_wr !== 1'b0 || bus.bm_a !== 7'd0 || bus.bm_d !== 8'd0 ||
        bus.rpt_valid !== 1'b0 || label_max !== 8'd0 || overflow !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL midscan reset: got a=%0d wr=%b max=%0d done=%b want all 0", bus.sram_a, bus.bm_wr, label_max, done); end
    @(negedge clk); reset = 1'b1;
    ready_mode = 0;
    run_scan(cyc);
    check_scan("after_reset");
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    foreach (mem[p]) mem[p] = 8'h00;
    test_reset();
    test_all_zero();
    test_all_one();
    test_corners();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
